// File: rtl/dram_arbiter.sv
// Two-port (fetch + data) arbiter in front of a single-port DRAM model.
// Sequences multi-cycle RD/WR strobes and returns results with one-cycle valid pulses.
module dram_arbiter #(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RD_LAT   = 2,
    parameter int unsigned WR_CYC   = 1,
    parameter int unsigned FAIR_MAX = 4
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    output logic              IGnt,
    output logic [DATA_W-1:0] IData,
    output logic              IValid,
    input  logic              DReq,
    input  logic              DWe,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWData,
    output logic              DGnt,
    output logic [DATA_W-1:0] DRData,
    output logic              DValid,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemDataIn,
    output logic              MemRD,
    output logic              MemWR,
    input  logic [DATA_W-1:0] MemDataOut,
    output logic              Busy
);

    localparam int unsigned LAT_MAX = (RD_LAT > WR_CYC) ? RD_LAT : WR_CYC;
    localparam int unsigned CNT_W   = $clog2(LAT_MAX + 1);
    localparam int unsigned FCNT_W  = $clog2(FAIR_MAX + 1);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t              state_q, state_d;
    logic [FCNT_W-1:0]   fair_q, fair_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                src_is_d_q, src_is_d_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rd_q, rd_d;
    logic                wr_q, wr_d;
    logic [DATA_W-1:0]   idata_q, idata_d;
    logic [DATA_W-1:0]   drdata_q, drdata_d;
    logic                ivalid_q, ivalid_d;
    logic                dvalid_q, dvalid_d;
    logic                busy_q, busy_d;

    logic                idle_c;
    logic                force_c;
    logic                igrant_c;
    logic                dgrant_c;

    // Grants are combinational and only offered from IDLE
    assign idle_c   = (state_q == IDLE);
    assign force_c  = (fair_q == FCNT_W'(FAIR_MAX));
    assign dgrant_c = idle_c & DReq & ~force_c;
    assign igrant_c = idle_c & IReq & (~DReq | force_c);

    assign IGnt      = igrant_c;
    assign DGnt      = dgrant_c;
    assign IData     = idata_q;
    assign IValid    = ivalid_q;
    assign DRData    = drdata_q;
    assign DValid    = dvalid_q;
    assign MemAddr   = addr_q;
    assign MemDataIn = wdata_q;
    assign MemRD     = rd_q;
    assign MemWR     = wr_q;
    assign Busy      = busy_q;

    always_comb begin
        state_d    = state_q;
        fair_d     = fair_q;
        cnt_d      = cnt_q;
        src_is_d_d = src_is_d_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        idata_d    = idata_q;
        drdata_d   = drdata_q;
        ivalid_d   = 1'b0;
        dvalid_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Fairness counter only moves on IDLE edges
                if (igrant_c) begin
                    fair_d = '0;
                end else if (dgrant_c && IReq) begin
                    if (!force_c) fair_d = fair_q + FCNT_W'(1);
                end else if (!IReq) begin
                    fair_d = '0;
                end

                if (dgrant_c) begin
                    src_is_d_d = 1'b1;
                    addr_d     = DAddr;
                    wdata_d    = DWData;
                    if (DWe) begin
                        state_d = WRITE;
                        wr_d    = 1'b1;
                        cnt_d   = CNT_W'(WR_CYC - 1);
                    end else begin
                        state_d = READ;
                        rd_d    = 1'b1;
                        cnt_d   = CNT_W'(RD_LAT - 1);
                    end
                end else if (igrant_c) begin
                    src_is_d_d = 1'b0;
                    addr_d     = IAddr;
                    state_d    = READ;
                    rd_d       = 1'b1;
                    cnt_d      = CNT_W'(RD_LAT - 1);
                end
            end
            READ: begin
                if (cnt_q == '0) begin
                    rd_d    = 1'b0;
                    state_d = RESP;
                    if (src_is_d_q) begin
                        drdata_d = MemDataOut;
                        dvalid_d = 1'b1;
                    end else begin
                        idata_d  = MemDataOut;
                        ivalid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            WRITE: begin
                if (cnt_q == '0) begin
                    wr_d     = 1'b0;
                    state_d  = RESP;
                    dvalid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                rd_d    = 1'b0;
                wr_d    = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q    <= IDLE;
            fair_q     <= '0;
            cnt_q      <= '0;
            src_is_d_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            idata_q    <= '0;
            drdata_q   <= '0;
            ivalid_q   <= 1'b0;
            dvalid_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            fair_q     <= fair_d;
            cnt_q      <= cnt_d;
            src_is_d_q <= src_is_d_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            idata_q    <= idata_d;
            drdata_q   <= drdata_d;
            ivalid_q   <= ivalid_d;
            dvalid_q   <= dvalid_d;
            busy_q     <= busy_d;
        end
    end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a small DRAM model (256 words, default word = A000+addr).
module tb_dram_arbiter;

    logic        Clk, Rst;
    logic        IReq, IGnt, IValid;
    logic [15:0] IAddr, IData;
    logic        DReq, DWe, DGnt, DValid;
    logic [15:0] DAddr, DWData, DRData;
    logic [15:0] MemAddr, MemDataIn, MemDataOut;
    logic        MemRD, MemWR, Busy;

    int total = 0;
    int bad   = 0;

    logic [15:0] mem [256];
    logic        mem_init;

    dram_arbiter #(
        .ADDR_W(16), .DATA_W(16), .RD_LAT(2), .WR_CYC(1), .FAIR_MAX(4)
    ) dut (
        .Clk(Clk), .Rst(Rst),
        .IReq(IReq), .IAddr(IAddr), .IGnt(IGnt), .IData(IData), .IValid(IValid),
        .DReq(DReq), .DWe(DWe), .DAddr(DAddr), .DWData(DWData),
        .DGnt(DGnt), .DRData(DRData), .DValid(DValid),
        .MemAddr(MemAddr), .MemDataIn(MemDataIn), .MemRD(MemRD), .MemWR(MemWR),
        .MemDataOut(MemDataOut), .Busy(Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // DRAM model: synchronous write, combinational read while RD is high
    always @(posedge Clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hA000 + 16'(i);
        end else if (MemWR) begin
            mem[MemAddr[7:0]] <= MemDataIn;
        end
    end
    assign MemDataOut = MemRD ? mem[MemAddr[7:0]] : 16'h0000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to the next negedge; caller drives then waits #1 before checking
    task automatic next_cyc();
        @(negedge Clk);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (Busy === 1'b1 && n < 20) begin
            next_cyc(); #1;
            n++;
        end
        check(tag, 32'(Busy), 32'd0);
    endtask

    logic [9:0] exp_pat;
    logic [9:0] got_pat;
    int         ngnt;

    initial begin
        Rst = 1'b1; mem_init = 1'b1;
        IReq = 0; IAddr = '0; DReq = 0; DWe = 0; DAddr = '0; DWData = '0;
        repeat (3) next_cyc();
        #1;
        check("rst_memrd",  32'(MemRD), 32'd0);
        check("rst_memwr",  32'(MemWR), 32'd0);
        check("rst_addr",   32'(MemAddr), 32'd0);
        check("rst_din",    32'(MemDataIn), 32'd0);
        check("rst_idata",  32'(IData), 32'd0);
        check("rst_drdata", 32'(DRData), 32'd0);
        check("rst_valid",  {30'd0, IValid, DValid}, 32'd0);
        check("rst_busy",   32'(Busy), 32'd0);
        mem_init = 1'b0;

        // Write 5555 <= F00D
        next_cyc(); Rst = 1'b0;
        DReq = 1; DWe = 1; DAddr = 16'h5555; DWData = 16'hF00D; #1;
        check("wr_dgnt", {30'd0, IGnt, DGnt}, 32'b01);
        next_cyc(); DReq = 0; #1;
        check("wr_c1_memwr", {30'd0, MemRD, MemWR}, 32'b01);
        check("wr_c1_addr", 32'(MemAddr), 32'h5555);
        check("wr_c1_din", 32'(MemDataIn), 32'hF00D);
        check("wr_c1_busy", 32'(Busy), 32'd1);
        check("wr_c1_dvalid", 32'(DValid), 32'd0);
        next_cyc(); #1;
        check("wr_c2_memwr", 32'(MemWR), 32'd0);
        check("wr_c2_dvalid", 32'(DValid), 32'd1);
        check("wr_c2_busy", 32'(Busy), 32'd1);
        check("wr_c2_drdata", 32'(DRData), 32'd0);

        // Read back 5555
        next_cyc(); DReq = 1; DWe = 0; DAddr = 16'h5555; #1;
        check("rd_busy0", 32'(Busy), 32'd0);
        check("rd_dvalid0", 32'(DValid), 32'd0);
        check("rd_dgnt", 32'(DGnt), 32'd1);
        next_cyc(); DReq = 0; #1;
        check("rd_c1_memrd", {30'd0, MemRD, MemWR}, 32'b10);
        check("rd_c1_ivalid", 32'(IValid), 32'd0);
        next_cyc(); #1;
        check("rd_c2_memrd", 32'(MemRD), 32'd1);
        check("rd_c2_dvalid", 32'(DValid), 32'd0);
        next_cyc(); #1;
        check("rd_c3_memrd", 32'(MemRD), 32'd0);
        check("rd_c3_dvalid", 32'(DValid), 32'd1);
        check("rd_c3_drdata", 32'(DRData), 32'hF00D);
        check("rd_c3_ivalid", 32'(IValid), 32'd0);

        // Simultaneous requests: data first, then fetch; IReq toggled while busy
        next_cyc(); IReq = 1; IAddr = 16'h0010; DReq = 1; DWe = 0; DAddr = 16'h0020; #1;
        check("both_c0_gnt", {30'd0, IGnt, DGnt}, 32'b01);
        next_cyc(); DReq = 0; #1;
        check("both_c1_ignt", 32'(IGnt), 32'd0);
        next_cyc(); #1;
        next_cyc(); #1;
        check("both_c3_dvalid", 32'(DValid), 32'd1);
        check("both_c3_drdata", 32'(DRData), 32'hA020);
        check("both_c3_ignt", 32'(IGnt), 32'd0);
        next_cyc(); #1;
        check("both_c4_gnt", {30'd0, IGnt, DGnt}, 32'b10);
        next_cyc(); IReq = 1; #1;
        check("tog_c5_ignt", 32'(IGnt), 32'd0);
        check("tog_c5_addr", 32'(MemAddr), 32'h0010);
        check("tog_c5_memrd", 32'(MemRD), 32'd1);
        next_cyc(); IReq = 0; IAddr = 16'h0077; #1;
        check("tog_c6_addr", 32'(MemAddr), 32'h0010);
        next_cyc(); IReq = 1; #1;
        check("tog_c7_ignt", 32'(IGnt), 32'd0);
        check("tog_c7_addr", 32'(MemAddr), 32'h0010);
        check("tog_c7_ivalid", 32'(IValid), 32'd1);
        check("tog_c7_idata", 32'(IData), 32'hA010);
        check("tog_c7_dvalid", 32'(DValid), 32'd0);

        // Fairness: both held high; expect D D D D I D D D D I (1 = fetch grant)
        exp_pat = 10'b1000010000;
        got_pat = '0;
        ngnt = 0;
        next_cyc(); IReq = 1; IAddr = 16'h0040; DReq = 1; DWe = 0; DAddr = 16'h0030; #1;
        for (int c = 0; c < 80 && ngnt < 10; c++) begin
            if (c > 0) begin next_cyc(); #1; end
            if (IGnt === 1'b1 && DGnt === 1'b1) check("fair_excl", 32'd3, 32'd1);
            if (IGnt === 1'b1 || DGnt === 1'b1) begin
                got_pat[ngnt] = IGnt;
                ngnt++;
            end
        end
        check("fair_count", 32'(ngnt), 32'd10);
        for (int k = 0; k < 10; k++) check($sformatf("fair_gnt%0d", k), 32'(got_pat[k]), 32'(exp_pat[k]));
        next_cyc(); IReq = 0; DReq = 0; #1;
        wait_idle("fair_idle");

        // Reset asserted in cycle 1 of a read
        next_cyc(); DReq = 1; DWe = 0; DAddr = 16'h0055; #1;
        check("rr_dgnt", 32'(DGnt), 32'd1);
        next_cyc(); DReq = 0; #1;
        check("rr_c1_memrd", 32'(MemRD), 32'd1);
        Rst = 1'b1; #1;
        check("rr_memrd_drop", 32'(MemRD), 32'd0);
        check("rr_busy", 32'(Busy), 32'd0);
        check("rr_addr", 32'(MemAddr), 32'd0);
        check("rr_drdata", 32'(DRData), 32'd0);
        next_cyc(); Rst = 1'b0; DReq = 1; DWe = 0; DAddr = 16'h0010; #1;
        check("rr_no_dvalid", 32'(DValid), 32'd0);
        check("rr_regnt", 32'(DGnt), 32'd1);
        next_cyc(); DReq = 0; #1;
        check("rr_c1_dvalid", 32'(DValid), 32'd0);
        next_cyc(); #1;
        next_cyc(); #1;
        check("rr_c3_dvalid", 32'(DValid), 32'd1);
        check("rr_c3_drdata", 32'(DRData), 32'hA010);
        next_cyc(); #1;
        check("rr_c4_dvalid", 32'(DValid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
